// File: rtl/axi_mm2s_reader_if.sv
// AXI4 read channels (AR/R) and AXI-Stream output of the MM2S reader.
// The reader drives the master modport; memory and stream sink use the slave modport.
interface axi_mm2s_reader_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 6
);
  logic [ID_WIDTH-1:0]   m_axi_arid;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic                  m_axi_arlock;
  logic [3:0]            m_axi_arcache;
  logic [2:0]            m_axi_arprot;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [ID_WIDTH-1:0]   m_axi_rid;
  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;

  modport master (
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/axi_mm2s_reader.sv
// AXI4 read-burst DMA: streams (addr, beats) regions out on AXI-Stream with TLAST.
// Optional macro AXI_MM2S_RRESP_CHECK_EN enables the sticky RRESP error flag.
module axi_mm2s_reader #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 128,
  parameter int ID_WIDTH      = 6,
  parameter int AXI_ID        = 0,
  parameter int MAX_BURST_LEN = 16,
  parameter int FIFO_DEPTH    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [31:0]           cmd_beats_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  axi_mm2s_reader_if.master     bus
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           remaining_q, beats_q, out_cnt_q;
  logic [CW-1:0]         reserved_q, reserved_d;
  logic [CW-1:0]         ram_cnt_q, ram_cnt_d;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [7:0]            arlen_q;
  logic                  arvalid_q, rready_q, done_q, out_valid_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [31:0] to4k, len_d, burst_len;
  logic        ar_hs, r_hs, pop, load, credit_ok, cmd_accept, tlast;
  logic [CW-1:0] occ;

  assign cmd_accept = cmd_valid_i & (state_q == S_IDLE);
  assign ar_hs      = arvalid_q & bus.m_axi_arready;
  assign r_hs       = bus.m_axi_rvalid & rready_q;
  assign pop        = out_valid_q & bus.m_axis_tready;
  assign load       = (ram_cnt_q != '0) & (~out_valid_q | pop);
  assign burst_len  = 32'(arlen_q) + 32'd1;
  assign occ        = ram_cnt_q + CW'(out_valid_q);
  assign tlast      = out_valid_q & (out_cnt_q == beats_q - 32'd1);

  // Beats left before the next 4 KiB page; addr_q is always beat-aligned.
  assign to4k = (32'd4096 - {20'd0, addr_q[11:0]}) >> SIZE;

  always_comb begin
    len_d = remaining_q;
    if (len_d > 32'(MAX_BURST_LEN)) len_d = 32'(MAX_BURST_LEN);
    if (len_d > to4k) len_d = to4k;
  end

  // A burst may only be requested once the FIFO can absorb every beat in flight.
  assign credit_ok = (32'(occ) + 32'(reserved_q) + len_d) <= 32'(FIFO_DEPTH);

  always_comb begin
    reserved_d = reserved_q;
    if (ar_hs) reserved_d = reserved_d + CW'(burst_len);
    if (r_hs)  reserved_d = reserved_d - CW'(1);
    ram_cnt_d = ram_cnt_q;
    if (r_hs) ram_cnt_d = ram_cnt_d + CW'(1);
    if (load) ram_cnt_d = ram_cnt_d - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      out_cnt_q   <= '0;
      reserved_q  <= '0;
      arlen_q     <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rready_q   <= 1'b1;
      done_q     <= 1'b0;
      reserved_q <= reserved_d;
      if (pop) out_cnt_q <= out_cnt_q + 32'd1;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            addr_q      <= cmd_addr_i & ~ADDR_WIDTH'(BYTES - 1);
            remaining_q <= cmd_beats_i;
            beats_q     <= cmd_beats_i;
            out_cnt_q   <= '0;
            if (cmd_beats_i == 32'd0) done_q  <= 1'b1;
            else                      state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (ar_hs) begin
            arvalid_q   <= 1'b0;
            addr_q      <= addr_q + ADDR_WIDTH'(burst_len << SIZE);
            remaining_q <= remaining_q - burst_len;
            if (remaining_q == burst_len) state_q <= S_DRAIN;
          end else if (!arvalid_q && credit_ok) begin
            arvalid_q <= 1'b1;
            arlen_q   <= 8'(len_d - 32'd1);
          end
        end
        S_DRAIN: begin
          if (pop && tlast) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Beat buffer: RAM with registered read feeding the first-word-fall-through output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ram_cnt_q <= ram_cnt_d;
      if (r_hs) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (load) begin
        rd_ptr_q    <= rd_ptr_q + PW'(1);
        out_valid_q <= 1'b1;
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_hs) mem_q[wr_ptr_q] <= bus.m_axi_rdata;
    if (load) tdata_q <= mem_q[rd_ptr_q];
  end

`ifdef AXI_MM2S_RRESP_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst)                                   err_q <= 1'b0;
    else if (r_hs && bus.m_axi_rresp != 2'b00) err_q <= 1'b1;
    else if (cmd_accept)                       err_q <= 1'b0;
  end
  assign err_o = err_q;
  logic unused_r;
  assign unused_r = ^{bus.m_axi_rid, bus.m_axi_rlast};
`else
  assign err_o = 1'b0;
  logic unused_r;
  assign unused_r = ^{bus.m_axi_rid, bus.m_axi_rlast, bus.m_axi_rresp, cmd_accept};
`endif

  assign cmd_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;

  assign bus.m_axi_arid    = ID_WIDTH'(AXI_ID);
  assign bus.m_axi_araddr  = addr_q;
  assign bus.m_axi_arlen   = arlen_q;
  assign bus.m_axi_arsize  = 3'(SIZE);
  assign bus.m_axi_arburst = 2'b01;
  assign bus.m_axi_arlock  = 1'b0;
  assign bus.m_axi_arcache = 4'b0000;
  assign bus.m_axi_arprot  = 3'b000;
  assign bus.m_axi_arvalid = arvalid_q;
  assign bus.m_axi_rready  = rready_q;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tvalid = out_valid_q;
  assign bus.m_axis_tlast  = tlast;
endmodule

// File: tb/tb_axi_mm2s_reader.sv
// Bench for axi_mm2s_reader: throttled AXI memory model, expected-beat and expected-AR
// scoreboards, done-pulse timing, credit bound and reset-value checks.
module tb_axi_mm2s_reader;
  localparam int AW  = 32;
  localparam int DW  = 128;
  localparam int IW  = 6;
  localparam int MBL = 16;
  localparam int FD  = 64;
`ifdef AXI_MM2S_RRESP_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0]   cmd_beats = '0;
  logic          busy, done, err;

  always #5 clk = ~clk;

  axi_mm2s_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  axi_mm2s_reader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .AXI_ID(0),
    .MAX_BURST_LEN(MBL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_addr_i(cmd_addr), .cmd_beats_i(cmd_beats),
    .busy_o(busy), .done_o(done), .err_o(err),
    .bus(bus)
  );

  typedef struct { logic [DW-1:0] data; logic last; } beat_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;

  beat_t exp_q[$];
  ar_t   exp_ar[$];
  ar_t   mem_bq[$];

  int n_checks = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0, pop_cnt = 0, outstanding = 0, max_out = 0;
  int cur_left = 0, tready_mode = 0;
  logic [31:0] cur_addr = '0;
  logic rv = 1'b0, rv_hold = 1'b0, rst_req = 1'b1, rst_prev = 1'b0;
  logic want_cmd = 1'b0, accepted = 1'b0, pend_done = 1'b0, busy_seen = 1'b0;
  logic force_slverr = 1'b0, ar_hold = 1'b0;
  logic [40:0] ar_hold_val = '0;

  function automatic logic [DW-1:0] mem_data(input logic [31:0] a);
    return {~a, a ^ 32'h5A5A_5A5A, a + 32'h1234_5678, a};
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: observe outputs at the falling edge, drive inputs, and account for
  // the handshakes that the next rising edge will complete.
  task automatic step();
    ar_t b;
    beat_t e;
    logic ar_hs, r_hs, pop;
    @(negedge clk);
    cyc++;
    if (rst_prev) begin
      check_eq("rst_cmd_ready", cmd_ready, 1'b1);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_err", err, 1'b0);
      check_eq("rst_arvalid", bus.m_axi_arvalid, 1'b0);
      check_eq("rst_rready", bus.m_axi_rready, 1'b0);
      check_eq("rst_tvalid", bus.m_axis_tvalid, 1'b0);
      check_eq("rst_tlast", bus.m_axis_tlast, 1'b0);
    end
    if (done || pend_done) check_eq("done_pulse", done, pend_done);
    if (done) done_cnt++;
    busy_seen = busy_seen | busy;
    pend_done = 1'b0;
    if (ar_hold)
      check_eq("ar_stable", {bus.m_axi_arvalid, bus.m_axi_araddr, bus.m_axi_arlen}, ar_hold_val);

    rst = rst_req;
    rst_prev = rst_req;
    if (rst_req) begin
      cmd_valid = 1'b0;
      bus.m_axi_arready = 1'b0;
      bus.m_axi_rvalid = 1'b0;
      bus.m_axis_tready = 1'b0;
      exp_q.delete(); exp_ar.delete(); mem_bq.delete();
      cur_left = 0; rv = 1'b0; rv_hold = 1'b0; ar_hold = 1'b0;
      outstanding = 0; want_cmd = 1'b0;
      return;
    end

    cmd_valid = want_cmd;
    bus.m_axi_arready = ($urandom_range(0, 3) != 0);
    case (tready_mode)
      0:       bus.m_axis_tready = 1'b1;
      1:       bus.m_axis_tready = (cyc % 4 == 0);
      default: bus.m_axis_tready = ($urandom_range(0, 1) != 0);
    endcase
    if (cur_left == 0 && mem_bq.size() > 0) begin
      b = mem_bq.pop_front();
      cur_addr = b.addr;
      cur_left = int'(b.len) + 1;
    end
    if (!rv_hold) rv = (cur_left > 0) && ($urandom_range(0, 3) != 0);
    bus.m_axi_rvalid = rv;
    bus.m_axi_rdata  = mem_data(cur_addr);
    bus.m_axi_rresp  = (force_slverr && rv) ? 2'b10 : 2'b00;
    bus.m_axi_rlast  = (cur_left == 1);
    bus.m_axi_rid    = '0;

    if (cmd_valid && cmd_ready) begin
      want_cmd = 1'b0;
      accepted = 1'b1;
      if (cmd_beats == 32'd0) pend_done = 1'b1;
    end

    ar_hs = bus.m_axi_arvalid && bus.m_axi_arready;
    ar_hold = bus.m_axi_arvalid && !bus.m_axi_arready;
    ar_hold_val = {bus.m_axi_arvalid, bus.m_axi_araddr, bus.m_axi_arlen};
    if (ar_hs) begin
      check_eq("ar_expected", exp_ar.size() > 0, 1'b1);
      if (exp_ar.size() > 0) begin
        b = exp_ar.pop_front();
        check_eq("araddr", bus.m_axi_araddr, b.addr);
        check_eq("arlen", bus.m_axi_arlen, b.len);
      end
      check_eq("ar_attr", {bus.m_axi_arid, bus.m_axi_arsize, bus.m_axi_arburst, bus.m_axi_arlock,
                           bus.m_axi_arcache, bus.m_axi_arprot},
               {6'd0, 3'd4, 2'b01, 1'b0, 4'd0, 3'd0});
      outstanding += int'(bus.m_axi_arlen) + 1;
      if (outstanding > max_out) max_out = outstanding;
      check_eq("credit", outstanding <= FD, 1'b1);
      mem_bq.push_back('{addr: bus.m_axi_araddr, len: bus.m_axi_arlen});
    end

    r_hs = rv && bus.m_axi_rready;
    if (r_hs) begin
      cur_addr = cur_addr + 32'd16;
      cur_left--;
    end
    rv_hold = rv && !r_hs;

    pop = bus.m_axis_tvalid && bus.m_axis_tready;
    if (pop) begin
      outstanding--;
      pop_cnt++;
      check_eq("beat_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("tdata", bus.m_axis_tdata, e.data);
        check_eq("tlast", bus.m_axis_tlast, e.last);
        if (e.last) pend_done = 1'b1;
      end
    end
  endtask

  task automatic run_cmd(input string name, input logic [31:0] a, input logic [31:0] n,
                         input int stop_after, input logic exp_err, input int budget);
    logic [31:0] base;
    int t;
    base = a & ~32'hF;
    for (int i = 0; i < int'(n); i++)
      exp_q.push_back('{data: mem_data(base + 32'(i) * 32'd16), last: (i == int'(n) - 1)});
    done_cnt = 0; pop_cnt = 0; busy_seen = 1'b0; max_out = 0;
    cmd_addr = a; cmd_beats = n; want_cmd = 1'b1; accepted = 1'b0; t = 0;
    while (!accepted && t < budget) begin step(); t++; end
    check_eq({name, "_accept"}, accepted, 1'b1);
    while (((stop_after == 0) ? (done_cnt == 0) : (pop_cnt < stop_after)) && t < budget) begin
      step(); t++;
    end
    if (stop_after != 0) begin
      check_eq({name, "_partial"}, pop_cnt >= stop_after, 1'b1);
      $display("cmd %s addr=%08h beats=%0d interrupted after %0d beats", name, a, n, pop_cnt);
    end else begin
      step(); step();
      check_eq({name, "_done_once"}, done_cnt, 1);
      check_eq({name, "_beats_left"}, exp_q.size(), 0);
      check_eq({name, "_ars_left"}, exp_ar.size(), 0);
      check_eq({name, "_busy_after"}, busy, 1'b0);
      check_eq({name, "_err"}, err, exp_err);
      $display("cmd %s addr=%08h beats=%0d popped=%0d cycles=%0d", name, a, n, pop_cnt, t);
    end
  endtask

  initial begin
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rvalid  = 1'b0;
    bus.m_axi_rdata   = '0;
    bus.m_axi_rresp   = 2'b00;
    bus.m_axi_rlast   = 1'b0;
    bus.m_axi_rid     = '0;
    bus.m_axis_tready = 1'b0;
    rst_req = 1'b1;
    repeat (3) step();
    rst_req = 1'b0;
    step();

    tready_mode = 0;
    exp_ar.push_back('{addr: 32'h1000, len: 8'd0});
    run_cmd("t1_single", 32'h1000, 32'd1, 0, 1'b0, 500);

    tready_mode = 2;
    exp_ar.push_back('{addr: 32'h000, len: 8'd15});
    exp_ar.push_back('{addr: 32'h100, len: 8'd15});
    exp_ar.push_back('{addr: 32'h200, len: 8'd7});
    run_cmd("t2_split16", 32'h0, 32'd40, 0, 1'b0, 1000);

    exp_ar.push_back('{addr: 32'hF80, len: 8'd7});
    exp_ar.push_back('{addr: 32'h1000, len: 8'd7});
    run_cmd("t3_4k", 32'hF80, 32'd16, 0, 1'b0, 1000);

    tready_mode = 1;
    for (int i = 0; i < 12; i++) exp_ar.push_back('{addr: 32'h2000 + 32'(i) * 32'h100, len: 8'd15});
    exp_ar.push_back('{addr: 32'h2C00, len: 8'd7});
    run_cmd("t4_credit", 32'h2000, 32'd200, 0, 1'b0, 3000);
    check_eq("t4_credit_reached", max_out > FD - MBL, 1'b1);

    tready_mode = 0;
    run_cmd("t5_zero", 32'h40, 32'd0, 0, 1'b0, 100);
    check_eq("t5_never_busy", busy_seen, 1'b0);

    tready_mode = 2;
    for (int i = 0; i < 4; i++) exp_ar.push_back('{addr: 32'(i) * 32'h100, len: 8'd15});
    run_cmd("t6_pre_reset", 32'h0, 32'd64, 10, 1'b0, 1000);
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    step();
    force_slverr = 1'b1;
    exp_ar.push_back('{addr: 32'h500, len: 8'd3});
    run_cmd("t6_after_reset", 32'h500, 32'd4, 0, ERR_EN, 500);
    force_slverr = 1'b0;

    exp_ar.push_back('{addr: 32'h3000, len: 8'd2});
    run_cmd("t7_unaligned", 32'h3007, 32'd3, 0, 1'b0, 500);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
